// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared widths, watchdog limit and FSM state type for the instruction fetch
// sequencer (fetch_sequencer) and its optional watchdog (fetch_timeout_cnt).
// No ports.
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int unsigned ADDR_W      = 12;
    localparam int unsigned INSTR_W     = 19;
    localparam int unsigned TIMEOUT_CYC = 15;
    localparam int unsigned CNT_W       = 4;

    typedef enum logic [1:0] {
        StClear  = 2'd0,
        StReq    = 2'd1,
        StHold   = 2'd2,
        StHalted = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_timeout_cnt.sv
// -----------------------------------------------------------------------------
// fetch_timeout_cnt
// Memory-read watchdog. Counts consecutive cycles in which a read is pending
// without an acknowledge; on the TIMEOUT_CYC-th such cycle it pulses o_expire
// and sets a sticky error flag that only i_rst clears.
// Only instantiated when FETCH_TIMEOUT_EN is defined.
//
// Ports
//   i_clk     system clock
//   i_rst     synchronous active-high reset
//   i_run     a read is waiting this cycle (in REQ, no ACK, no redirect)
//   o_expire  this cycle is the last permitted waiting cycle
//   o_err     sticky timeout error
// -----------------------------------------------------------------------------
module fetch_timeout_cnt
    import fetch_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_run,
    output logic o_expire,
    output logic o_err
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
    logic             w_expire;

    assign w_expire = i_run && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

    // Counter restarts whenever the wait ends (ACK, redirect, or leaving REQ).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (i_run && !w_expire) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt <= '0;
            end
            if (w_expire) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_expire = w_expire;
    assign o_err    = r_err;

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Instruction fetch FSM (CLEAR -> REQ -> HOLD -> REQ ..., HALTED on request).
// Drives strobes to an external PC register (priority LOAD > INC > CLR), issues
// instruction reads, holds the fetched word in IR until execute accepts it and
// services branch redirects.
// Optional macro FETCH_TIMEOUT_EN compiles in a memory-timeout watchdog;
// without it REQ waits forever and o_fetch_err is tied low.
//
// Ports
//   i_clk, i_rst               clock, synchronous active-high reset
//   i_pc_val                   current PC register value
//   o_pc_load/o_pc_inc/o_pc_clr  PC strobes (at most one per cycle)
//   o_pc_target                load value, zero unless o_pc_load
//   o_mem_rd, o_mem_addr       read request and address
//   i_mem_ack, i_mem_data      read complete and instruction word
//   o_ir_out, o_ir_valid       fetched instruction and its valid
//   i_ir_ready                 execute accepts the instruction
//   i_br_take, i_br_addr       redirect request and target
//   i_halt                     stop fetching after the current instruction
//   o_fetch_err                sticky memory-timeout flag
// -----------------------------------------------------------------------------
module fetch_sequencer
    import fetch_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [ADDR_W-1:0]  i_pc_val,
    output logic               o_pc_load,
    output logic               o_pc_inc,
    output logic               o_pc_clr,
    output logic [ADDR_W-1:0]  o_pc_target,
    output logic               o_mem_rd,
    output logic [ADDR_W-1:0]  o_mem_addr,
    input  logic               i_mem_ack,
    input  logic [INSTR_W-1:0] i_mem_data,
    output logic [INSTR_W-1:0] o_ir_out,
    output logic               o_ir_valid,
    input  logic               i_ir_ready,
    input  logic               i_br_take,
    input  logic [ADDR_W-1:0]  i_br_addr,
    input  logic               i_halt,
    output logic               o_fetch_err
);

    fetch_state_e       r_state;
    fetch_state_e       w_state_next;
    logic [INSTR_W-1:0] r_ir;
    logic               w_expire;
    logic               w_err;

`ifdef FETCH_TIMEOUT_EN
    logic w_run;

    assign w_run = (r_state == StReq) && !i_mem_ack && !i_br_take;

    fetch_timeout_cnt u_timeout (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_run    (w_run),
        .o_expire (w_expire),
        .o_err    (w_err)
    );
`else
    assign w_expire = 1'b0;
    assign w_err    = 1'b0;
`endif

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StClear;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Instruction register: a redirect in the ACK cycle discards the data.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ir <= '0;
        end else if ((r_state == StReq) && i_mem_ack && !i_br_take) begin
            r_ir <= i_mem_data;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StClear: begin
                w_state_next = StReq;
            end
            StReq: begin
                // HALT is deliberately not looked at here: the read must finish.
                if (i_br_take) begin
                    w_state_next = StReq;
                end else if (i_mem_ack) begin
                    w_state_next = StHold;
                end else if (w_expire) begin
                    w_state_next = StHalted;
                end
            end
            StHold: begin
                if (i_br_take) begin
                    w_state_next = StReq;
                end else if (i_ir_ready) begin
                    w_state_next = i_halt ? StHalted : StReq;
                end
            end
            StHalted: begin
                // A timeout halt is only left through reset.
                if (!i_halt && !w_err) begin
                    w_state_next = StReq;
                end
            end
            default: begin
                w_state_next = StClear;
            end
        endcase
    end

    // Output logic
    always_comb begin
        o_pc_load   = 1'b0;
        o_pc_inc    = 1'b0;
        o_pc_clr    = 1'b0;
        o_pc_target = '0;
        o_mem_rd    = 1'b0;
        o_mem_addr  = '0;
        o_ir_valid  = 1'b0;
        if (i_rst) begin
            // Reset overrides the current state combinationally as well.
            o_pc_clr = 1'b1;
        end else begin
            unique case (r_state)
                StClear: begin
                    o_pc_clr = 1'b1;
                end
                StReq: begin
                    o_mem_rd   = 1'b1;
                    o_mem_addr = i_pc_val;
                    if (i_br_take) begin
                        o_pc_load   = 1'b1;
                        o_pc_target = i_br_addr;
                    end else if (i_mem_ack) begin
                        o_pc_inc = 1'b1;
                    end
                end
                StHold: begin
                    o_ir_valid = 1'b1;
                    if (i_br_take) begin
                        o_pc_load   = 1'b1;
                        o_pc_target = i_br_addr;
                    end
                end
                StHalted: begin
                end
                default: begin
                end
            endcase
        end
    end

    assign o_ir_out    = r_ir;
    assign o_fetch_err = w_err;

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
// Self-checking bench for fetch_sequencer. Models the external PC register,
// pushes expected instruction words when an accepted MEM_ACK is driven and
// pops them when the IR handshake occurs. Honours FETCH_TIMEOUT_EN.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;
    import fetch_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic [ADDR_W-1:0]  pc_val = 12'h5A5;
    logic               pc_load, pc_inc, pc_clr;
    logic [ADDR_W-1:0]  pc_target;
    logic               mem_rd;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_ack;
    logic [INSTR_W-1:0] mem_data;
    logic [INSTR_W-1:0] ir_out;
    logic               ir_valid;
    logic               ir_ready;
    logic               br_take;
    logic [ADDR_W-1:0]  br_addr;
    logic               halt;
    logic               fetch_err;

    int n_checks = 0;
    int n_fail   = 0;
    logic [INSTR_W-1:0] exp_q[$];

    fetch_sequencer dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_pc_val    (pc_val),
        .o_pc_load   (pc_load),
        .o_pc_inc    (pc_inc),
        .o_pc_clr    (pc_clr),
        .o_pc_target (pc_target),
        .o_mem_rd    (mem_rd),
        .o_mem_addr  (mem_addr),
        .i_mem_ack   (mem_ack),
        .i_mem_data  (mem_data),
        .o_ir_out    (ir_out),
        .o_ir_valid  (ir_valid),
        .i_ir_ready  (ir_ready),
        .i_br_take   (br_take),
        .i_br_addr   (br_addr),
        .i_halt      (halt),
        .o_fetch_err (fetch_err)
    );

    always #5 clk = ~clk;

    // External PC register: LOAD > INC > CLR, natural 12-bit wrap.
    always @(posedge clk) begin
        if (pc_load)     pc_val <= pc_target;
        else if (pc_inc) pc_val <= pc_val + 12'd1;
        else if (pc_clr) pc_val <= '0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected strobe vector {load, inc, clr}
    task automatic check_str(input string tag, input logic [2:0] exp);
        check(tag, 32'({pc_load, pc_inc, pc_clr}), 32'(exp));
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle invariants and scoreboard drain on the IR handshake.
    always @(negedge clk) begin
        check("onehot", 32'($countones({pc_load, pc_inc, pc_clr}) <= 1), 32'd1);
        if (!pc_load) check("tgt_zero", 32'(pc_target), 32'd0);
        if (ir_valid && ir_ready && rst === 1'b0) begin
            if (exp_q.size() == 0) check("sb_underflow", 32'(exp_q.size()), 32'd1);
            else check("ir_sb", 32'(ir_out), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time %0t, expected completion earlier", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        rst = 1'b1; mem_ack = 1'b0; mem_data = '0; ir_ready = 1'b0;
        br_take = 1'b0; br_addr = '0; halt = 1'b0;
        advance();
        // Reset, with a stray ACK that must be ignored
        mem_ack = 1'b1; mem_data = 19'h7FFFF;
        repeat (3) begin
            @(negedge clk);
            check_str("rst_str", 3'b001);
            check("rst_rd", 32'(mem_rd), 32'd0);
            check("rst_irv", 32'(ir_valid), 32'd0);
            check("rst_ir", 32'(ir_out), 32'd0);
            check("rst_err", 32'(fetch_err), 32'd0);
            advance();
        end
        // First cycle after reset: CLEAR, branch ignored
        rst = 1'b0; mem_ack = 1'b0; br_take = 1'b1; br_addr = 12'h123;
        @(negedge clk);
        check_str("clr_str", 3'b001);
        check("clr_rd", 32'(mem_rd), 32'd0);
        advance();
        br_take = 1'b0; br_addr = '0;
        // REQ: two waiting cycles, then ACK
        repeat (2) begin
            @(negedge clk);
            check("req0_rd", 32'(mem_rd), 32'd1);
            check("req0_addr", 32'(mem_addr), 32'h000);
            check_str("req0_str", 3'b000);
            advance();
        end
        mem_ack = 1'b1; mem_data = 19'h1ABCD; exp_q.push_back(19'h1ABCD);
        @(negedge clk);
        check_str("ack0_str", 3'b010);
        check("ack0_addr", 32'(mem_addr), 32'h000);
        advance();
        mem_ack = 1'b0; mem_data = '0;
        // HOLD with IR_READY low for 5 cycles
        repeat (5) begin
            @(negedge clk);
            check("hold_irv", 32'(ir_valid), 32'd1);
            check("hold_ir", 32'(ir_out), 32'h1ABCD);
            check("hold_rd", 32'(mem_rd), 32'd0);
            check_str("hold_str", 3'b000);
            advance();
        end
        ir_ready = 1'b1;
        @(negedge clk);
        check("hs_irv", 32'(ir_valid), 32'd1);
        advance();
        @(negedge clk);
        check("req1_rd", 32'(mem_rd), 32'd1);
        check("req1_addr", 32'(mem_addr), 32'h001);
        check("req1_irv", 32'(ir_valid), 32'd0);
        advance();
        // Branch in the ACK cycle: branch wins, data discarded
        mem_ack = 1'b1; mem_data = 19'h12345; br_take = 1'b1; br_addr = 12'h3F0;
        @(negedge clk);
        check_str("brack_str", 3'b100);
        check("brack_tgt", 32'(pc_target), 32'h3F0);
        advance();
        mem_ack = 1'b0; br_take = 1'b0; br_addr = '0;
        @(negedge clk);
        check("br_irv", 32'(ir_valid), 32'd0);
        check("br_ir_kept", 32'(ir_out), 32'h1ABCD);
        check("br_rd", 32'(mem_rd), 32'd1);
        check("br_addr", 32'(mem_addr), 32'h3F0);
        advance();
        mem_ack = 1'b1; mem_data = 19'h0F0F0; exp_q.push_back(19'h0F0F0);
        @(negedge clk);
        check_str("ack2_str", 3'b010);
        advance();
        mem_ack = 1'b0;
        @(negedge clk);
        check("hold2_irv", 32'(ir_valid), 32'd1);
        advance();
        // HALT during REQ: read completes, handshake, then HALTED
        halt = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("halt_req_rd", 32'(mem_rd), 32'd1);
            check("halt_req_addr", 32'(mem_addr), 32'h3F1);
            advance();
        end
        mem_ack = 1'b1; mem_data = 19'h55555; exp_q.push_back(19'h55555);
        @(negedge clk);
        check_str("halt_ack_str", 3'b010);
        advance();
        mem_ack = 1'b0;
        @(negedge clk);
        check("halt_hold_irv", 32'(ir_valid), 32'd1);
        advance();
        repeat (2) begin
            @(negedge clk);
            check("halted_rd", 32'(mem_rd), 32'd0);
            check("halted_irv", 32'(ir_valid), 32'd0);
            check_str("halted_str", 3'b000);
            advance();
        end
        halt = 1'b0;
        @(negedge clk);
        check("unhalt_rd0", 32'(mem_rd), 32'd0);
        advance();
        @(negedge clk);
        check("resume_rd", 32'(mem_rd), 32'd1);
        check("resume_addr", 32'(mem_addr), 32'h3F2);
        advance();
        // Branch together with the IR handshake, to 12'hFFF
        mem_ack = 1'b1; mem_data = 19'h2AAAA; exp_q.push_back(19'h2AAAA);
        @(negedge clk);
        check_str("ack4_str", 3'b010);
        advance();
        mem_ack = 1'b0; br_take = 1'b1; br_addr = 12'hFFF;
        @(negedge clk);
        check("brhs_irv", 32'(ir_valid), 32'd1);
        check_str("brhs_str", 3'b100);
        check("brhs_tgt", 32'(pc_target), 32'hFFF);
        advance();
        br_take = 1'b0; br_addr = '0;
        @(negedge clk);
        check("brhs_addr", 32'(mem_addr), 32'hFFF);
        check("brhs_irv2", 32'(ir_valid), 32'd0);
        advance();
        mem_ack = 1'b1; mem_data = 19'h00FFF; exp_q.push_back(19'h00FFF);
        @(negedge clk);
        check_str("ack5_str", 3'b010);
        advance();
        mem_ack = 1'b0;
        @(negedge clk);
        check("hold5_irv", 32'(ir_valid), 32'd1);
        advance();
        @(negedge clk);
        check("wrap_addr", 32'(mem_addr), 32'h000);
        advance();
        // Reset while in HOLD
        mem_ack = 1'b1; mem_data = 19'h31337; ir_ready = 1'b0;
        @(negedge clk);
        check_str("ack6_str", 3'b010);
        advance();
        mem_ack = 1'b0;
        @(negedge clk);
        check("hold6_ir", 32'(ir_out), 32'h31337);
        check("hold6_irv", 32'(ir_valid), 32'd1);
        advance();
        rst = 1'b1;
        @(negedge clk);
        check_str("rsthold_str", 3'b001);
        check("rsthold_rd", 32'(mem_rd), 32'd0);
        advance();
        rst = 1'b0;
        @(negedge clk);
        check("rsthold_irv", 32'(ir_valid), 32'd0);
        check("rsthold_ir", 32'(ir_out), 32'd0);
        check_str("rsthold_clr", 3'b001);
        advance();
        @(negedge clk);
        check("restart_rd", 32'(mem_rd), 32'd1);
        check("restart_addr", 32'(mem_addr), 32'h000);
`ifdef FETCH_TIMEOUT_EN
        // Watchdog: 15 waiting cycles in REQ, then HALTED with sticky error
        for (int i = 2; i <= 15; i++) begin
            advance();
            @(negedge clk);
            check("to_wait_rd", 32'(mem_rd), 32'd1);
            check("to_wait_err", 32'(fetch_err), 32'd0);
        end
        advance();
        br_take = 1'b1; br_addr = 12'h0AA;
        repeat (4) begin
            @(negedge clk);
            check("to_err", 32'(fetch_err), 32'd1);
            check("to_rd", 32'(mem_rd), 32'd0);
            check_str("to_str", 3'b000);
            advance();
        end
        br_take = 1'b0; br_addr = '0;
`else
        repeat (20) begin
            advance();
            @(negedge clk);
            check("wait_rd", 32'(mem_rd), 32'd1);
            check("wait_err", 32'(fetch_err), 32'd0);
        end
        advance();
`endif
        rst = 1'b1;
        advance();
        rst = 1'b0;
        @(negedge clk);
        check("rst2_err", 32'(fetch_err), 32'd0);
        check_str("rst2_clr", 3'b001);
        advance();
        @(negedge clk);
        check("rst2_rd", 32'(mem_rd), 32'd1);
        check("rst2_addr", 32'(mem_addr), 32'h000);
        advance();
        mem_ack = 1'b1; mem_data = 19'h0BEEF; ir_ready = 1'b1; exp_q.push_back(19'h0BEEF);
        @(negedge clk);
        check_str("ack7_str", 3'b010);
        advance();
        mem_ack = 1'b0;
        @(negedge clk);
        check("hold7_irv", 32'(ir_valid), 32'd1);
        advance();
        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of CLK.
REQ-002 CLK  input  1  system clock.
REQ-003 RST  input  1  synchronous active-high reset.
REQ-004 PC_VAL  input  12  current program-counter register value.
REQ-005 PC_LOAD / PC_INC / PC_CLR  output  1 each  strobes to the 12-bit PC register, which applies priority LOAD > INC > CLR.
REQ-006 PC_TARGET  output  12  load value presented with PC_LOAD.
REQ-007 MEM_RD  output  1  instruction read request; MEM_ADDR  output  12  read address.
REQ-008 MEM_ACK  input  1  read complete; MEM_DATA  input  19  instruction word, valid when MEM_ACK=1.
REQ-009 IR_OUT  output  19  fetched instruction; IR_VALID  output  1  IR_OUT valid; IR_READY  input  1  execute accepts.
REQ-010 BR_TAKE  input  1  redirect request; BR_ADDR  input  12  redirect target.
REQ-011 HALT  input  1  stop fetching; FETCH_ERR  output  1  memory timeout flag (see REQ-030).

Function
REQ-012 The FSM SHALL have states CLEAR, REQ, HOLD and HALTED.
REQ-013 In CLEAR: PC_CLR=1 and all other outputs inactive; next state is REQ.
REQ-014 In REQ: MEM_RD=1 and MEM_ADDR=PC_VAL, both held stable until MEM_ACK.
REQ-015 REQ with MEM_ACK=1: IR_OUT<=MEM_DATA, PC_INC=1 in the same cycle, next state HOLD; fetch latency is 1 cycle after the ACK cycle.
REQ-016 In HOLD: IR_VALID=1 and IR_OUT stable until the IR_VALID&IR_READY cycle; next state is then REQ, or HALTED if HALT=1.
REQ-017 The sequencer SHALL assert at most one of PC_LOAD/PC_INC/PC_CLR per cycle.
REQ-018 BR_TAKE=1 in REQ or HOLD: PC_LOAD=1 and PC_TARGET=BR_ADDR that cycle, IR_VALID=0 the next cycle, next state REQ.
REQ-019 BR_TAKE and MEM_ACK in the same cycle: the branch wins, MEM_DATA is discarded, IR_OUT is unchanged and PC_INC=0.
REQ-020 BR_TAKE and the IR handshake in the same cycle: the instruction counts as consumed and PC_LOAD is still issued.
REQ-021 BR_TAKE in CLEAR or HALTED SHALL be ignored.
REQ-022 HALT in REQ SHALL take effect only after the pending read completes (the HOLD handshake); an outstanding MEM_RD is never withdrawn except by BR_TAKE or RST.
REQ-023 In HALTED: no strobes and MEM_RD=0; next state is REQ when HALT=0.
REQ-024 PC wrap 12'hFFF -> 12'h000 is produced by the PC register; the sequencer applies no special handling.
REQ-025 PC_TARGET SHALL be 0 whenever PC_LOAD=0.

Reset
REQ-026 RST=1 SHALL force state CLEAR, IR_OUT=0, IR_VALID=0, MEM_RD=0, FETCH_ERR=0 and the timeout counter to 0, taking priority over every other input.
REQ-027 PC_CLR SHALL be 1 throughout reset and for the first cycle after RST falls.
REQ-028 RST asserted mid-read SHALL abandon the read; a MEM_ACK arriving during or after reset while not in REQ SHALL be ignored.

Configuration
REQ-029 Macro FETCH_TIMEOUT_EN SHALL compile in a memory-timeout watchdog.
REQ-030 With the macro defined: a 4-bit counter runs in REQ and clears on exit. When it reaches 15 cycles without MEM_ACK, FETCH_ERR=1 (sticky until RST), MEM_RD=0 and the state goes to HALTED, which it does not leave until RST.
REQ-031 With the macro undefined: REQ waits indefinitely, FETCH_ERR is tied to 0 and no counter logic exists.

Structure
REQ-032 Package fetch_pkg SHALL hold ADDR_W=12, INSTR_W=19, TIMEOUT_CYC=15 and the FSM state enum.
REQ-033 One sub-module, fetch_timeout_cnt, SHALL contain the watchdog and be instantiated only under FETCH_TIMEOUT_EN; everything else stays in fetch_sequencer.

Verification
REQ-034 Reset, then PC_VAL=0 and MEM_ACK after 2 cycles with MEM_DATA=19'h1ABCD -> PC_CLR during reset, MEM_ADDR=0, IR_OUT=19'h1ABCD with IR_VALID, and a single PC_INC.
REQ-035 IR_READY held 0 for 5 cycles -> IR_VALID and IR_OUT stay stable, MEM_RD=0, no strobes; IR_READY=1 -> REQ issued the next cycle.
REQ-036 BR_TAKE=1 with BR_ADDR=12'h3F0 in the same cycle as MEM_ACK -> PC_LOAD only (no PC_INC), IR_OUT unchanged, the next MEM_ADDR equals 12'h3F0.
REQ-037 HALT=1 during REQ -> the read completes, the handshake occurs, then HALTED with MEM_RD=0; HALT=0 -> REQ resumes.
REQ-038 With FETCH_TIMEOUT_EN, MEM_ACK withheld for 15 cycles -> FETCH_ERR=1 and MEM_RD=0, and the block stays halted until RST.
REQ-039 RST pulsed while in HOLD -> IR_VALID=0 the next cycle, PC_CLR=1, and the fetch restarts in REQ from address 0.
